stateful_cxu_lanes: RTL
=======================

// Module: stateful_cxu_lanes
// PURPOSE
//  Parametrised stateful CXU: treats the host-held state vector as LANES unsigned lanes of LANE_W bits.
//  Executes lane-wise update, lane read/write, clear and multi-cycle sum-reduction commands per function_id.
//  Sits behind the CPU CXU port. The host state file supplies state_read for the selected state_id
//  and commits state_write on state_write_en. One command in flight; registered response with valid/ready.
// PARAMETERS
//  STATE_W    2048  state vector width in bits; multiple of LANE_W
//  LANE_W     8     lane width in bits; 1..32
//  RED_LANES  32    lanes summed per REDUCE cycle; LANES % RED_LANES == 0
//  (derived) LANES = STATE_W/LANE_W; RED_CYC = LANES/RED_LANES; IDX_W = clog2(LANES)
// PORTS
//  clk                      in   1        clock, rising edge
//  reset                    in   1        reset; asynchronous, active-low
//  cmd_valid                in   1        command valid
//  cmd_ready                out  1        command accepted when cmd_valid && cmd_ready
//  cmd_payload_function_id  in   3        opcode, see BEHAVIOUR
//  cmd_payload_inputs_0     in   32       operand A
//  cmd_payload_inputs_1     in   32       operand B
//  cmd_payload_state_id     in   3        state context; selects state_read in host, unused internally
//  cmd_payload_cxu_id       in   4        unused
//  cmd_payload_ready        in   1        unused
//  rsp_valid                out  1        response valid, held until rsp_ready
//  rsp_ready                in   1        response consumed when rsp_valid && rsp_ready
//  rsp_payload_outputs_0    out  32       result, stable while rsp_valid
//  rsp_payload_ready        out  1        constant 1
//  state_read               in   STATE_W  current state of selected context
//  state_write              out  STATE_W  new state, valid when state_write_en
//  state_write_en           out  1        one-cycle commit strobe
// BEHAVIOUR
//  Reset: FSM=IDLE; cmd_ready=1; rsp_valid=0; rsp_payload_outputs_0=0; state_write=0; state_write_en=0.
//   Reset mid-REDUCE or with rsp pending: command dropped, no response, no state write.
//  FSM: IDLE --accept, op!=SUM--> RESP; IDLE --accept SUM--> REDUCE; REDUCE --cnt==RED_CYC-1--> RESP;
//   RESP --rsp_ready--> IDLE. cmd_ready = (FSM==IDLE); no back-to-back accept, so state_read is fresh.
//  Single-cycle ops: compute from state_read in accept cycle N. rsp_valid and state_write_en rise
//   in N+1. state_write_en is high for exactly one cycle (N+1) even if rsp stalls.
//  Lane i = state[i*LANE_W +: LANE_W]; idx = inputs_0[IDX_W-1:0] (mod LANES); all lane math wraps mod 2^LANE_W.
//  f0 INC_IF: if inputs_0==inputs_1, every lane +1 and write; out=1. Else no write; out=0.
//  f1 ADD   : every lane += inputs_0[LANE_W-1:0], write; out=0.
//  f2 READ  : out = zero-extended lane[idx]; no write.
//  f3 WRITE : lane[idx] = inputs_1[LANE_W-1:0], other lanes unchanged, write; out = old lane[idx].
//  f4 CLEAR : state_write = 0, write; out=0.
//  f5 SUM   : out = sum of all lanes, unsigned, 32-bit wrap; no write. Accumulator cleared on accept.
//   REDUCE cycle k adds lanes [k*RED_LANES, (k+1)*RED_LANES). Counter 0..RED_CYC-1.
//   rsp_valid rises RED_CYC+1 cycles after accept; default config is 9.
//   Host contract: state_read for latched state_id is stable until rsp fires.
//  f6,f7    : illegal; out = 32'hFFFF_FFFF; no write; latency 1.
//  Operands and opcode are latched on accept. Input changes while busy are ignored.
//  cmd_valid while busy is not accepted and not lost; the host holds it.
// STRUCTURE
//  Package stateful_cxu_pkg: function_id localparams/enum (INC_IF..SUM), FSM state enum {IDLE,REDUCE,RESP},
//   ILLEGAL_RSP constant.
//  Sub-module cxu_lane_reducer: combinational adder of RED_LANES x LANE_W lanes -> 32-bit partial sum.
//   Instantiated once; slice is selected by the reduce counter.
//  Top: FSM, operand latches, reduce counter and accumulator, lane-update generate loop, output regs.
// TESTING
//  Reset low mid-SUM (cycle 3) -> rsp_valid=0, state_write_en=0, cmd_ready=1 after release; no stale rsp later.
//  INC_IF in0=in1=10, all lanes 0xFF -> all lanes 0x00 written, out=1, write_en 1 cycle. in0=10,in1=11 -> no write, out=0.
//  WRITE idx=LANES+3 (wraps to 3), in1=0x1A5 -> lane3=0xA5, out=old lane3. Then READ idx=3 -> out=0x000000A5.
//  SUM with all lanes 0xFF (2048/8) -> out=256*255=0x0000FF00 at cycle accept+9; cmd_ready=0 throughout.
//  rsp_ready held low 5 cycles after ADD in0=3 -> rsp/out stable, write_en pulses once, cmd_valid not accepted until handshake.
//  f6 and f7 -> out=0xFFFFFFFF, no write. Repeat SUM with STATE_W=64, LANE_W=16, RED_LANES=2 -> 2 REDUCE cycles.

Source files
------------

// File: rtl/stateful_cxu_pkg.sv
// Shared opcode, FSM state and response constants for the stateful lane CXU.
package stateful_cxu_pkg;

  typedef enum logic [2:0] {
    FN_INC_IF = 3'd0,
    FN_ADD    = 3'd1,
    FN_READ   = 3'd2,
    FN_WRITE  = 3'd3,
    FN_CLEAR  = 3'd4,
    FN_SUM    = 3'd5
  } cxu_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_RESP   = 2'd2
  } cxu_state_e;

  localparam logic [31:0] ILLEGAL_RSP = 32'hFFFF_FFFF;

endpackage

// File: rtl/cxu_lane_reducer.sv
// Combinational adder tree: RED_LANES unsigned lanes of LANE_W bits summed into a 32-bit wrapping total.
module cxu_lane_reducer #(
  parameter int LANE_W    = 8,
  parameter int RED_LANES = 32
) (
  input  logic [RED_LANES*LANE_W-1:0] lanes,
  output logic [31:0]                 sum
);

  // Zero-extend each lane and accumulate modulo 2^32.
  always_comb begin
    sum = 32'd0;
    for (int i = 0; i < RED_LANES; i++) begin
      sum = sum + 32'(lanes[i*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/stateful_cxu_lanes.sv
// Stateful CXU treating the host state vector as LANES lanes; single-cycle lane ops plus a multi-cycle SUM.
module stateful_cxu_lanes
  import stateful_cxu_pkg::*;
#(
  parameter int STATE_W   = 2048,
  parameter int LANE_W    = 8,
  parameter int RED_LANES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_payload_function_id,
  input  logic [31:0]        cmd_payload_inputs_0,
  input  logic [31:0]        cmd_payload_inputs_1,
  input  logic [2:0]         cmd_payload_state_id,
  input  logic [3:0]         cmd_payload_cxu_id,
  input  logic               cmd_payload_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_payload_outputs_0,
  output logic               rsp_payload_ready,
  input  logic [STATE_W-1:0] state_read,
  output logic [STATE_W-1:0] state_write,
  output logic               state_write_en
);

  localparam int LANES   = STATE_W / LANE_W;
  localparam int RED_CYC = LANES / RED_LANES;
  localparam int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W   = (RED_CYC > 1) ? $clog2(RED_CYC) : 1;
  localparam int SLICE_W = RED_LANES * LANE_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RED_CYC - 1);

  cxu_state_e         fsm_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        acc_r;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  logic               wr_en_r;
  logic [31:0]        out_r;
  logic [STATE_W-1:0] wr_data_r;

  logic               accept_s;
  logic [IDX_W-1:0]   idx_s;
  logic [LANE_W-1:0]  sel_lane_s;
  logic [STATE_W-1:0] next_state_s;
  logic [31:0]        result_s;
  logic               do_write_s;
  logic [SLICE_W-1:0] slice_s;
  logic [31:0]        partial_s;
  logic               unused_s;

  assign unused_s   = ^{cmd_payload_state_id, cmd_payload_cxu_id, cmd_payload_ready};
  assign accept_s   = cmd_valid && cmd_ready_r;
  assign idx_s      = cmd_payload_inputs_0[IDX_W-1:0];
  assign sel_lane_s = state_read[int'(idx_s)*LANE_W +: LANE_W];
  assign slice_s    = state_read[int'(cnt_r)*SLICE_W +: SLICE_W];

  cxu_lane_reducer #(
    .LANE_W    (LANE_W),
    .RED_LANES (RED_LANES)
  ) u_reducer (
    .lanes (slice_s),
    .sum   (partial_s)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] cur_s;
    logic [LANE_W-1:0] nxt_s;
    assign cur_s = state_read[i*LANE_W +: LANE_W];
    assign next_state_s[i*LANE_W +: LANE_W] = nxt_s;

    // New value of this lane for the opcode presented in the accept cycle.
    always_comb begin
      nxt_s = cur_s;
      case (cmd_payload_function_id)
        FN_INC_IF: nxt_s = cur_s + LANE_W'(1);
        FN_ADD:    nxt_s = cur_s + cmd_payload_inputs_0[LANE_W-1:0];
        FN_WRITE: begin
          if (idx_s == IDX_W'(i)) begin
            nxt_s = cmd_payload_inputs_1[LANE_W-1:0];
          end else begin
            nxt_s = cur_s;
          end
        end
        FN_CLEAR:  nxt_s = {LANE_W{1'b0}};
        default:   nxt_s = cur_s;
      endcase
    end
  end

  // Response word and write decision for single-cycle opcodes.
  always_comb begin
    result_s   = ILLEGAL_RSP;
    do_write_s = 1'b0;
    case (cmd_payload_function_id)
      FN_INC_IF: begin
        if (cmd_payload_inputs_0 == cmd_payload_inputs_1) begin
          result_s   = 32'd1;
          do_write_s = 1'b1;
        end else begin
          result_s   = 32'd0;
          do_write_s = 1'b0;
        end
      end
      FN_ADD:   begin result_s = 32'd0;              do_write_s = 1'b1; end
      FN_READ:  begin result_s = 32'(sel_lane_s);    do_write_s = 1'b0; end
      FN_WRITE: begin result_s = 32'(sel_lane_s);    do_write_s = 1'b1; end
      FN_CLEAR: begin result_s = 32'd0;              do_write_s = 1'b1; end
      FN_SUM:   begin result_s = 32'd0;              do_write_s = 1'b0; end
      default:  begin result_s = ILLEGAL_RSP;        do_write_s = 1'b0; end
    endcase
  end

  // Command FSM; all handshake and state-commit outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_r       <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= 32'd0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      wr_en_r     <= 1'b0;
      out_r       <= 32'd0;
      wr_data_r   <= {STATE_W{1'b0}};
    end else begin
      wr_en_r <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            if (cmd_payload_function_id == FN_SUM) begin
              fsm_r <= ST_REDUCE;
              cnt_r <= {CNT_W{1'b0}};
              acc_r <= 32'd0;
            end else begin
              fsm_r       <= ST_RESP;
              rsp_valid_r <= 1'b1;
              out_r       <= result_s;
              wr_en_r     <= do_write_s;
              if (do_write_s) begin
                wr_data_r <= next_state_s;
              end
            end
          end
        end
        ST_REDUCE: begin
          acc_r <= acc_r + partial_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            fsm_r       <= ST_RESP;
            rsp_valid_r <= 1'b1;
            out_r       <= acc_r + partial_s;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            fsm_r       <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          fsm_r       <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready             = cmd_ready_r;
  assign rsp_valid             = rsp_valid_r;
  assign rsp_payload_outputs_0 = out_r;
  assign rsp_payload_ready     = 1'b1;
  assign state_write           = wr_data_r;
  assign state_write_en        = wr_en_r;

endmodule
